// File: rtl/pulse_responder.sv
// Far-end transponder: qualifies a receiver pulse and answers with one fixed-latency
// active-low reply. Define PULSE_RESPONDER_WIDTH_CHECK_EN to also reject over-wide pulses.
module pulse_responder #(
   parameter int MIN_WIDTH_CYC  = 2,
   parameter int MAX_WIDTH_CYC  = 10,
   parameter int TURNAROUND_CYC = 8,
   parameter int SWITCH_CYC     = 2,
   parameter int REPLY_CYC      = 4,
   parameter int HOLDOFF_CYC    = 16
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_Enable,
   input  logic        i_ReceivedData,
   output logic        o_DataIn,
   output logic        o_EnableAmplifier,
   output logic        o_AntennaTransmitter,
   output logic        o_AntennaReceiver,
   output logic        o_EnableReceiverPower,
   output logic        o_EnableLowNoiseAmplifier,
   output logic        o_busy,
   output logic        o_reply_done,
   output logic        o_reject,
   output logic [15:0] o_reply_count
);

   typedef enum logic [2:0] {
      S_OFF, S_LISTEN, S_MEASURE, S_WAIT_TURN, S_SWITCH_TX, S_EMIT, S_SWITCH_RX, S_HOLDOFF
   } state_t;

   if (MIN_WIDTH_CYC < 1 || MIN_WIDTH_CYC > 255 ||
       MAX_WIDTH_CYC < MIN_WIDTH_CYC || MAX_WIDTH_CYC > 255) begin : g_bad_width
      $error("pulse_responder: width parameters out of range");
   end

   state_t      state_q, state_d;
   logic        rx_meta_q, rx_s_q, rx_prev_q;
   logic [7:0]  tmr_q, tmr_d;
   logic [7:0]  wid_q, wid_d;
   logic [15:0] reply_cnt_q, reply_cnt_d;
   logic        rx_rise, rx_fall, width_bad;
   logic        reject_d, done_d, tx_on_d, rx_on_d;
   logic        data_q, pa_q, ant_tx_q, ant_rx_q, rx_pwr_q, lna_q, busy_q, done_q, reject_q;

   assign rx_rise = rx_s_q & ~rx_prev_q;
   assign rx_fall = ~rx_s_q & rx_prev_q;

`ifdef PULSE_RESPONDER_WIDTH_CHECK_EN
   assign width_bad = (wid_q < 8'(MIN_WIDTH_CYC)) || (wid_q > 8'(MAX_WIDTH_CYC));
`else
   assign width_bad = (wid_q < 8'(MIN_WIDTH_CYC));
`endif

   // Timed states reload tmr to 0 on entry and leave after exactly N cycles.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q + 8'd1;
      wid_d       = wid_q;
      reply_cnt_d = reply_cnt_q;
      reject_d    = 1'b0;
      done_d      = 1'b0;
      if (!i_Enable) begin
         state_d = S_OFF;
      end else begin
         case (state_q)
            S_OFF:       state_d = S_LISTEN;
            S_LISTEN:    if (rx_rise) begin
                            state_d = S_MEASURE;
                            wid_d   = 8'd1;
                         end
            S_MEASURE:   if (rx_fall) begin
                            tmr_d = 8'd0;
                            if (width_bad) begin
                               reject_d = 1'b1;
                               state_d  = S_LISTEN;
                            end else begin
                               state_d  = S_WAIT_TURN;
                            end
                         end else if (rx_s_q && wid_q != 8'hFF) begin
                            wid_d = wid_q + 8'd1;
                         end
            S_WAIT_TURN: if (tmr_q == 8'(TURNAROUND_CYC - 1)) begin
                            state_d = S_SWITCH_TX;
                            tmr_d   = 8'd0;
                         end
            S_SWITCH_TX: if (tmr_q == 8'(SWITCH_CYC - 1)) begin
                            state_d = S_EMIT;
                            tmr_d   = 8'd0;
                         end
            S_EMIT:      if (tmr_q == 8'(REPLY_CYC - 1)) begin
                            state_d     = S_SWITCH_RX;
                            tmr_d       = 8'd0;
                            done_d      = 1'b1;
                            reply_cnt_d = reply_cnt_q + 16'd1;
                         end
            S_SWITCH_RX: if (tmr_q == 8'(SWITCH_CYC - 1)) begin
                            state_d = S_HOLDOFF;
                            tmr_d   = 8'd0;
                         end
            // A still-high input at exit produces no rising edge, so LISTEN waits for it to drop.
            S_HOLDOFF:   if (tmr_q == 8'(HOLDOFF_CYC - 1)) state_d = S_LISTEN;
            default:     state_d = S_OFF;
         endcase
      end
   end

   assign tx_on_d = (state_d inside {S_SWITCH_TX, S_EMIT});
   assign rx_on_d = (state_d inside {S_LISTEN, S_MEASURE, S_WAIT_TURN, S_SWITCH_RX, S_HOLDOFF});

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         rx_meta_q   <= 1'b0;
         rx_s_q      <= 1'b0;
         rx_prev_q   <= 1'b0;
         state_q     <= S_OFF;
         tmr_q       <= 8'd0;
         wid_q       <= 8'd0;
         reply_cnt_q <= 16'd0;
         data_q      <= 1'b1;
         pa_q        <= 1'b0;
         ant_tx_q    <= 1'b0;
         ant_rx_q    <= 1'b0;
         rx_pwr_q    <= 1'b0;
         lna_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         reject_q    <= 1'b0;
      end else begin
         rx_meta_q   <= i_ReceivedData;
         rx_s_q      <= rx_meta_q;
         rx_prev_q   <= rx_s_q;
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         wid_q       <= wid_d;
         reply_cnt_q <= reply_cnt_d;
         data_q      <= (state_d != S_EMIT);
         pa_q        <= tx_on_d;
         ant_tx_q    <= tx_on_d;
         ant_rx_q    <= rx_on_d;
         rx_pwr_q    <= rx_on_d;
         lna_q       <= rx_on_d;
         busy_q      <= !(state_d inside {S_OFF, S_LISTEN});
         done_q      <= done_d;
         reject_q    <= reject_d;
      end
   end

   assign o_DataIn                  = data_q;
   assign o_EnableAmplifier         = pa_q;
   assign o_AntennaTransmitter      = ant_tx_q;
   assign o_AntennaReceiver         = ant_rx_q;
   assign o_EnableReceiverPower     = rx_pwr_q;
   assign o_EnableLowNoiseAmplifier = lna_q;
   assign o_busy                    = busy_q;
   assign o_reply_done              = done_q;
   assign o_reject                  = reject_q;
   assign o_reply_count             = reply_cnt_q;

endmodule
